ifft_3_8: RTL and testbench
===========================

IFFT_3_8 -- requirements
Module: ifft_3_8

Interface
REQ-001 Parameter DBW, default 8: width of each signed two's-complement component (real, imaginary).
REQ-002 Parameter CBW, default 3: frame-slot counter width; only the value 3 (8-point) is supported.
REQ-003 Parameter FBW, default 6: fractional bits of twiddle constants (1.0 = 2^FBW = 0x40).
REQ-004 Port clk, input, 1: clock; all state is updated on the rising edge.
REQ-005 Port rstx, input, 1: reset, asynchronous, active-low.
REQ-006 Port clear, input, 1: synchronous frame restart.
REQ-007 Port din, input, 2*DBW: spectrum bin X[k], packed {im, re}.
REQ-008 Port dout, output, 2*DBW: time sample x[n], packed {im, re}.
REQ-009 Port dout_valid, output, 1: dout holds a sample of a completely received frame.
REQ-010 Port dout_first, output, 1: dout holds x[0] of a frame.

Function
REQ-011 Internal slot counter cnt (CBW bits) SHALL increment by 1 every cycle, wrapping 7->0, and SHALL load 0 on the cycle after clear=1.
REQ-012 The din sample taken when cnt==0 SHALL be bin X[0] of a new frame; one bin per cycle, no gaps, no stall.
REQ-013 Input bin order SHALL be bit-reversed: k = 0,4,2,6,1,5,3,7 for cnt = 0..7.
REQ-014 Output order SHALL be natural: n = 0..7 on consecutive cycles, starting at dout_first.
REQ-015 The block SHALL compute x[n] = (1/8) * sum_k X[k] * e^(+j*2*pi*k*n/8) using three radix-2 butterfly stages of span 1, 2, 4.
REQ-016 Each stage SHALL output (a + w*b)/2 and (a - w*b)/2, keeping DBW bits per component; the divide by 2 per stage gives the total 1/8 scaling.
REQ-017 Twiddles w SHALL be the constants 0x40 (1.0), 0x00 and 0x2D (45/64 ~ 0.7071), with sign per angle; complex products use DBW+FBW+2-bit intermediates, then shift right arithmetically by FBW.
REQ-018 Without rounding (see Configuration), every right shift SHALL truncate toward minus infinity.
REQ-019 Latency SHALL be fixed at LAT = 10 cycles: dout_first=1 exactly 10 cycles after the cycle in which din carried X[0]; padding registers are added if the datapath is shorter.
REQ-020 dout_first SHALL be 1 for exactly one cycle out of every 8 while frames stream.
REQ-021 dout_valid SHALL rise together with the first dout_first after reset or clear, and SHALL then stay 1 until the next clear or reset.
REQ-022 clear mid-frame SHALL discard the partial frame and flush the pipeline: dout_valid=0, dout_first=0 and dout=0 from the next cycle until the new frame's dout_first.
REQ-023 clear held for several cycles SHALL keep cnt at 0 and the outputs flushed; the frame starts on the first cycle with clear=0.
REQ-024 clear asserted in the same cycle that dout_first would rise SHALL suppress that dout_first.

Reset
REQ-025 rstx=0 SHALL immediately force cnt=0, all pipeline and delay registers to 0, dout=0, dout_valid=0 and dout_first=0.
REQ-026 After rstx deasserts, the first din with cnt==0 SHALL be treated as X[0], exactly as after clear.

Configuration
REQ-027 Macro IFFT_3_8_ROUND_EN defined: every per-stage /2 and every FBW shift SHALL round half-up (add half an LSB before the shift).
REQ-028 Macro IFFT_3_8_ROUND_EN undefined: all shifts SHALL truncate as in REQ-018; latency and ports are identical in both builds.

Verification
REQ-029 Impulse: X[0]=(re 64, im 0), all other bins 0 -> x[n]=(8,0) for n=0..7; dout_first 10 cycles after X[0].
REQ-030 Flat spectrum: all X[k]=(64,0) -> x[0]=(64,0), x[1..7]=(0,0).
REQ-031 Single bin X[1]=(64,0) -> x[0,2,4,6] = (8,0),(0,8),(-8,0),(0,-8) exactly; x[1,3,5,7] within 1 LSB of (±5.66, ±5.66) with signs per quadrant.
REQ-032 Rounding: X[0]=(7,0), rest 0 -> all x[n]=(0,0) with the macro undefined, and (1,0) with IFFT_3_8_ROUND_EN defined.
REQ-033 clear at cnt=5 mid-frame -> dout_valid=0 next cycle; a new impulse frame starting at cnt=0 gives dout_first and dout_valid=1 exactly 10 cycles later.
REQ-034 rstx pulsed low mid-stream -> all outputs 0 asynchronously; normal impulse response resumes 10 cycles after the first post-reset X[0].

Source files
------------

// File: rtl/ifft_3_8.sv
// ifft_3_8: streaming 8-point inverse FFT, one complex bin per clock.
// Bins arrive in bit-reversed order and are gathered into a frame buffer.
// The frame then passes through three radix-2 butterfly stages: span 1,
// then spans 2 and 4. Each stage halves its result, which gives the
// overall 1/8 scale. Samples leave in natural order with a fixed latency
// of 10 cycles.
// Optional build macro: IFFT_3_8_ROUND_EN. When it is defined, every shift
// rounds half-up. When it is undefined, every shift truncates toward minus
// infinity.
module ifft_3_8 #(
    parameter int DBW = 8,
    parameter int CBW = 3,
    parameter int FBW = 6
) (
    input  logic             clk,
    input  logic             rstx,
    input  logic             clear,
    input  logic [2*DBW-1:0] din,
    output logic [2*DBW-1:0] dout,
    output logic             dout_valid,
    output logic             dout_first
);

    localparam int SW = 2 * DBW;        // one packed sample {im, re}
    localparam int FW = 8 * SW;         // one whole frame, slot i at [i*SW +: SW]
    localparam int PW = DBW + FBW + 2;  // complex-product intermediate width
    localparam int TW = FBW + 2;        // twiddle constant width

    localparam logic signed [TW-1:0] W_ONE  = {2'b01, {FBW{1'b0}}};
    localparam logic signed [TW-1:0] W_ZERO = {TW{1'b0}};
    localparam logic signed [TW-1:0] W_R45  = TW'(7'd45);
    localparam logic signed [TW-1:0] W_M45  = -W_R45;

    localparam logic [CBW-1:0] CNT_ONE  = CBW'(1'b1);
    localparam logic [CBW-1:0] CNT_LAST = {CBW{1'b1}};

`ifdef IFFT_3_8_ROUND_EN
    localparam logic signed [PW-1:0]  RND_P = {{(PW-FBW){1'b0}}, 1'b1, {(FBW-1){1'b0}}};
    localparam logic signed [DBW+2:0] RND_S = {{(DBW+2){1'b0}}, 1'b1};
`else
    localparam logic signed [PW-1:0]  RND_P = {PW{1'b0}};
    localparam logic signed [DBW+2:0] RND_S = {(DBW+3){1'b0}};
`endif

    // Compute w*b. The twiddle w is (wr + j*wi) / 2^FBW. The result is
    // packed {im, re}, and each part is DBW+2 bits wide.
    function automatic logic [2*(DBW+2)-1:0] cmul(input logic [SW-1:0]        b,
                                                  input logic signed [TW-1:0] wr,
                                                  input logic signed [TW-1:0] wi);
        logic signed [DBW-1:0] br;
        logic signed [DBW-1:0] bi;
        logic signed [PW-1:0]  pr;
        logic signed [PW-1:0]  pi;
        br = b[DBW-1:0];
        bi = b[SW-1:DBW];
        pr = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi) + RND_P;
        pi = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr) + RND_P;
        return {(DBW+2)'(pi >>> FBW), (DBW+2)'(pr >>> FBW)};
    endfunction

    // Radix-2 butterfly. The return value is {(a - w*b)/2, (a + w*b)/2}.
    // The twiddle is e^(+j*pi*e/4), with e counted in eighth turns from 0 to 3.
    function automatic logic [2*SW-1:0] bfly(input logic [SW-1:0] a,
                                             input logic [SW-1:0] b,
                                             input logic [1:0]    e);
        logic signed [TW-1:0]      wr;
        logic signed [TW-1:0]      wi;
        logic [2*(DBW+2)-1:0]      t;
        logic signed [DBW+1:0]     tr;
        logic signed [DBW+1:0]     ti;
        logic signed [DBW-1:0]     ar;
        logic signed [DBW-1:0]     ai;
        logic signed [DBW+2:0]     pr;
        logic signed [DBW+2:0]     pi;
        logic signed [DBW+2:0]     mr;
        logic signed [DBW+2:0]     mi;
        case (e)
            2'd0:    begin wr = W_ONE;  wi = W_ZERO; end
            2'd1:    begin wr = W_R45;  wi = W_R45;  end
            2'd2:    begin wr = W_ZERO; wi = W_ONE;  end
            2'd3:    begin wr = W_M45;  wi = W_R45;  end
            default: begin wr = W_ONE;  wi = W_ZERO; end
        endcase
        t  = cmul(b, wr, wi);
        tr = t[DBW+1:0];
        ti = t[2*(DBW+2)-1:DBW+2];
        ar = a[DBW-1:0];
        ai = a[SW-1:DBW];
        pr = (DBW+3)'(ar) + (DBW+3)'(tr) + RND_S;
        pi = (DBW+3)'(ai) + (DBW+3)'(ti) + RND_S;
        mr = (DBW+3)'(ar) - (DBW+3)'(tr) + RND_S;
        mi = (DBW+3)'(ai) - (DBW+3)'(ti) + RND_S;
        return {DBW'(mi >>> 1), DBW'(mr >>> 1), DBW'(pi >>> 1), DBW'(pr >>> 1)};
    endfunction

    // Apply one butterfly stage of the given span to a whole frame.
    // Slot lo pairs with slot lo+span, and the twiddle steps by 4/span eighth turns.
    function automatic logic [FW-1:0] stage_f(input logic [FW-1:0] v, input int span);
        logic [FW-1:0]   r;
        logic [2*SW-1:0] y;
        int              lo;
        int              hi;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            lo = (p / span) * 2 * span + (p % span);
            hi = lo + span;
            y  = bfly(v[lo*SW +: SW], v[hi*SW +: SW], 2'((p % span) * (4 / span)));
            r[lo*SW +: SW] = y[SW-1:0];
            r[hi*SW +: SW] = y[2*SW-1:SW];
        end
        return r;
    endfunction

    logic [CBW-1:0]  cnt_q, cnt_d;
    logic [7*SW-1:0] buf_q, buf_d;      // bins of slots 0..6; slot 7 is taken straight from din
    logic [FW-1:0]   frame_s;
    logic [FW-1:0]   s1_q, s1_d;        // after the span-1 stage, loaded when slot 7 arrives
    logic [FW-1:0]   s2_s;
    logic [FW-1:0]   s3_q, s3_d;        // natural-order results, held for the whole output frame
    logic            full_q, full_d;    // a complete frame has entered the pipeline
    logic            first_q, first_d;
    logic            valid_q, valid_d;
    logic [SW-1:0]   dout_q, dout_d;
    logic [CBW-1:0]  oidx_s;
    logic [SW-1:0]   pick_s;

    // Next-state logic: slot counter, frame capture, butterfly stages and output sequencing.
    always_comb begin
        cnt_d = clear ? '0 : cnt_q + CNT_ONE;
        buf_d = buf_q;
        for (int s = 0; s < 7; s++) begin
            if (clear) begin
                buf_d[s*SW +: SW] = '0;
            end else if (cnt_q == CBW'(s)) begin
                buf_d[s*SW +: SW] = din;
            end else begin
                buf_d[s*SW +: SW] = buf_q[s*SW +: SW];
            end
        end
        frame_s = {din, buf_q};
        s1_d    = clear ? '0 : ((cnt_q == CNT_LAST) ? stage_f(frame_s, 32'd1) : s1_q);
        s2_s    = stage_f(s1_q, 32'd2);
        s3_d    = clear ? '0 : ((cnt_q == '0) ? stage_f(s2_s, 32'd4) : s3_q);
        full_d  = ~clear & (full_q | (cnt_q == CNT_LAST));
        first_d = ~clear & full_q & (cnt_q == CNT_ONE);
        valid_d = ~clear & (valid_q | first_d);
        oidx_s  = cnt_q - CNT_ONE;
        pick_s  = s3_q[oidx_s*SW +: SW];
        dout_d  = valid_d ? pick_s : '0;
    end

    // State registers. The asynchronous reset clears every stage and output.
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            cnt_q   <= '0;
            buf_q   <= '0;
            s1_q    <= '0;
            s3_q    <= '0;
            full_q  <= 1'b0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            s1_q    <= s1_d;
            s3_q    <= s3_d;
            full_q  <= full_d;
            first_q <= first_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_first = first_q;

endmodule

// File: tb/tb_ifft_3_8.sv
// Directed self-checking bench for ifft_3_8. It builds a per-cycle table of
// expected outputs, then checks dout, dout_valid and dout_first every cycle.
module tb_ifft_3_8;

    logic        clk;
    logic        rstx;
    logic        clear;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_first;

    int nvec;
    int nerr;
    int cyc;

    logic [15:0] exp_d [0:127];
    logic        exp_f [0:127];
    logic        exp_v [0:127];
    logic        chk_v [0:127];

    logic [15:0] imp_in  [8];
    logic [15:0] flat_in [8];
    logic [15:0] bin1_in [8];
    logic [15:0] rnd_in  [8];
    logic [15:0] zero_in [8];
    logic [15:0] imp_x   [8];
    logic [15:0] flat_x  [8];
    logic [15:0] bin1_x  [8];
    logic [15:0] rnd_x   [8];
    logic [15:0] zero_x  [8];

    ifft_3_8 dut (
        .clk        (clk),
        .rstx       (rstx),
        .clear      (clear),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_first (dout_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input int re, input int im);
        return {8'(im), 8'(re)};
    endfunction

    task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] expv);
        nvec++;
        assert (got === expv) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (chk_v[cyc]) begin
            chk_eq("dout", dout, exp_d[cyc]);
            chk_eq("dout_valid", {15'd0, dout_valid}, {15'd0, exp_v[cyc]});
            chk_eq("dout_first", {15'd0, dout_first}, {15'd0, exp_f[cyc]});
        end
    endtask

    task automatic expect_idle(input int c_from, input int c_to);
        for (int c = c_from; c <= c_to; c++) begin
            exp_d[c] = 16'h0000;
            exp_f[c] = 1'b0;
            exp_v[c] = 1'b0;
            chk_v[c] = 1'b1;
        end
    endtask

    task automatic expect_frame(input int c0, input logic [15:0] x [8]);
        for (int n = 0; n < 8; n++) begin
            exp_d[c0+10+n] = x[n];
            exp_f[c0+10+n] = (n == 0);
            exp_v[c0+10+n] = 1'b1;
            chk_v[c0+10+n] = 1'b1;
        end
    endtask

    task automatic send(input logic [15:0] f [8]);
        for (int s = 0; s < 8; s++) begin
            din = f[s];
            tick();
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        cyc  = 0;
        for (int c = 0; c < 128; c++) begin
            chk_v[c] = 1'b0;
            exp_d[c] = 16'h0000;
            exp_f[c] = 1'b0;
            exp_v[c] = 1'b0;
        end
        // The input frames below are listed in slot order, which is bit-reversed bin order.
        for (int i = 0; i < 8; i++) begin
            imp_in[i]  = 16'h0000;
            flat_in[i] = pk(64, 0);
            bin1_in[i] = 16'h0000;
            rnd_in[i]  = 16'h0000;
            zero_in[i] = 16'h0000;
            imp_x[i]   = pk(8, 0);
            flat_x[i]  = 16'h0000;
            zero_x[i]  = 16'h0000;
`ifdef IFFT_3_8_ROUND_EN
            rnd_x[i]   = pk(1, 0);
`else
            rnd_x[i]   = 16'h0000;
`endif
        end
        imp_in[0]  = pk(64, 0);
        rnd_in[0]  = pk(7, 0);
        bin1_in[4] = pk(64, 0);   // X[1] travels in slot 4
        flat_x[0]  = pk(64, 0);
        bin1_x[0]  = pk(8, 0);
        bin1_x[2]  = pk(0, 8);
        bin1_x[4]  = pk(-8, 0);
        bin1_x[6]  = pk(0, -8);
`ifdef IFFT_3_8_ROUND_EN
        bin1_x[1]  = pk(6, 6);
        bin1_x[3]  = pk(-5, 6);
        bin1_x[5]  = pk(-5, -5);
        bin1_x[7]  = pk(6, -5);
`else
        bin1_x[1]  = pk(5, 5);
        bin1_x[3]  = pk(-6, 5);
        bin1_x[5]  = pk(-6, -6);
        bin1_x[7]  = pk(6, -6);
`endif

        // Later calls overwrite earlier entries wherever a clear or reset cuts a frame off.
        expect_idle(0, 9);
        expect_frame(0, imp_x);
        expect_frame(8, flat_x);
        expect_frame(16, bin1_x);
        expect_frame(24, rnd_x);
        expect_idle(38, 47);
        expect_frame(38, imp_x);
        expect_idle(56, 67);
        expect_frame(58, imp_x);
        expect_idle(71, 81);
        expect_frame(72, imp_x);
        expect_frame(80, zero_x);

        // Hold reset with non-zero input, then check that every output is zero.
        rstx  = 1'b0;
        clear = 1'b0;
        din   = pk(5, 3);
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_dout", dout, 16'h0000);
        chk_eq("rst_valid", {15'd0, dout_valid}, 16'h0000);
        chk_eq("rst_first", {15'd0, dout_first}, 16'h0000);

        // Cycle 0 is the first cycle out of reset; it carries X[0].
        rstx = 1'b1;
        cyc  = 0;
        send(imp_in);
        send(flat_in);
        send(bin1_in);
        send(rnd_in);

        // Clear in slot 5 of a partial frame. The next frame starts at cycle 38.
        for (int s = 0; s < 6; s++) begin
            din   = 16'h0000;
            clear = (s == 5);
            tick();
        end
        clear = 1'b0;
        send(imp_in);
        send(flat_in);

        // Clear is held over cycles 55..57. It suppresses the flat frame's
        // dout_first, and the next frame starts at cycle 58.
        din = pk(9, 9);
        tick();
        clear = 1'b1;
        repeat (3) tick();
        clear = 1'b0;
        send(imp_in);
        for (int s = 0; s < 4; s++) begin
            din = flat_in[s];
            tick();
        end

        // Pull the reset low mid-stream at cycle 70; the outputs must clear at once.
        rstx = 1'b0;
        #1;
        chk_eq("async_dout", dout, 16'h0000);
        chk_eq("async_valid", {15'd0, dout_valid}, 16'h0000);
        chk_eq("async_first", {15'd0, dout_first}, 16'h0000);
        tick();
        tick();
        rstx = 1'b1;   // cycle 72 carries the first post-reset X[0]
        send(imp_in);
        send(zero_in);
        send(zero_in);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
